smp_opnd_stager: RTL

SMP_OPND_STAGER -- requirements
Module: smp_opnd_stager

---
 rtl/smp_opnd_stager_if.sv | 31 +++
 rtl/smp_opnd_stager.sv | 97 +++++++++
 2 files changed

// File: rtl/smp_opnd_stager_if.sv
// rtl/smp_opnd_stager_if.sv - operand/result handshake bundle for smp_opnd_stager
interface smp_opnd_stager_if #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic             OP_VALID;
    logic             OP_READY;
    logic [WIDTH-1:0] OP_A;
    logic [WIDTH-1:0] OP_B;
    logic [WIDTH-1:0] IN1;
    logic [WIDTH-1:0] IN2;
    logic [WIDTH-1:0] OUT1;
    logic [WIDTH-1:0] OUT2;
    logic             RES_VALID;
    logic             RES_READY;
    logic [WIDTH-1:0] RES1;
    logic [WIDTH-1:0] RES2;
    logic [LW-1:0]    LEVEL;

    modport slave (
        input  OP_VALID, OP_A, OP_B, OUT1, OUT2, RES_READY,
        output OP_READY, IN1, IN2, RES_VALID, RES1, RES2, LEVEL
    );

    modport master (
        output OP_VALID, OP_A, OP_B, OUT1, OUT2, RES_READY,
        input  OP_READY, IN1, IN2, RES_VALID, RES1, RES2, LEVEL
    );
endinterface

// File: rtl/smp_opnd_stager.sv
// rtl/smp_opnd_stager.sv - operand FIFO feeding a compare/arith stage and capturing its results
module smp_opnd_stager #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 4
) (
    input logic              CLK,
    input logic              RST,
    smp_opnd_stager_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    logic [WIDTH-1:0] r_mem_a [DEPTH];
    logic [WIDTH-1:0] r_mem_b [DEPTH];
    logic [AW-1:0]    r_wptr;
    logic [AW-1:0]    r_rptr;
    logic [LW-1:0]    r_count;
    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_in1;
    logic [WIDTH-1:0] r_in2;
    logic [WIDTH-1:0] r_res1;
    logic [WIDTH-1:0] r_res2;
    logic             r_res_valid;

    logic w_ready;
    logic w_push;
    logic w_pop;

    // Ready depends only on the registered count, never on a same-cycle pop.
    assign w_ready = (r_count < LW'(DEPTH));
    assign w_push  = bus.OP_VALID && w_ready;
    assign w_pop   = (r_state == IDLE) && (r_count != '0);

    assign bus.OP_READY  = w_ready;
    assign bus.LEVEL     = r_count;
    assign bus.IN1       = r_in1;
    assign bus.IN2       = r_in2;
    assign bus.RES1      = r_res1;
    assign bus.RES2      = r_res2;
    assign bus.RES_VALID = r_res_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= IDLE;
            r_wptr      <= '0;
            r_rptr      <= '0;
            r_count     <= '0;
            r_in1       <= '0;
            r_in2       <= '0;
            r_res1      <= '0;
            r_res2      <= '0;
            r_res_valid <= 1'b0;
        end else begin
            if (w_push) begin
                r_mem_a[r_wptr] <= bus.OP_A;
                r_mem_b[r_wptr] <= bus.OP_B;
                r_wptr          <= r_wptr + AW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + LW'(1);
                2'b01:   r_count <= r_count - LW'(1);
                default: r_count <= r_count;
            endcase

            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_in1   <= r_mem_a[r_rptr];
                        r_in2   <= r_mem_b[r_rptr];
                        r_state <= DRIVE;
                    end
                end
                // Operands have been stable for a full cycle; take the stage outputs.
                DRIVE: begin
                    r_res1      <= bus.OUT1;
                    r_res2      <= bus.OUT2;
                    r_res_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.RES_READY) begin
                        r_res_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
